// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter: rising-edge detector on N level channels with one
// pending event per channel, offered one at a time in round-robin order to a
// single consumer over a valid/ready handshake.
//
// Handshake: an event transfers at a posedge where ev_valid=1 and ev_ready=1.
// Once ev_valid is raised, ev_id is held until that transfer or until reset;
// ev_ready is ignored while ev_valid=0.
module edge_event_arbiter #(
  parameter  int N   = 4,
  localparam int IDW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   level,
  output logic           ev_valid,
  output logic [IDW-1:0] ev_id,
  input  logic           ev_ready,
  output logic [N-1:0]   pending,
  output logic [N-1:0]   overrun,
  input  logic [N-1:0]   ovr_clr
);

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_e;

  state_e         state_q, state_d;
  logic           ev_valid_q, ev_valid_d;
  logic [IDW-1:0] ev_id_q, ev_id_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [N-1:0]   lvl_q, lvl_d;
  logic [N-1:0]   pending_q, pending_d;
  logic [N-1:0]   overrun_q, overrun_d;

  logic [N-1:0]   rise;
  logic [N-1:0]   grant;
  logic           handshake;
  logic           pick_found;
  logic [IDW-1:0] pick_id;

  assign handshake = ev_valid_q & ev_ready;

  // Edge detection, grant decode, pending and sticky overrun update.
  always_comb begin
    lvl_d = level;
    rise  = level & ~lvl_q;
    grant = '0;
    if (handshake) begin
      grant[ev_id_q] = 1'b1;
    end
    // A rise coinciding with its own grant re-arms the channel as a new event.
    pending_d = (pending_q & ~grant) | rise;
    // An edge is lost only if the previous event is still pending and not
    // being consumed this cycle; a new loss wins over a clear.
    overrun_d = (overrun_q & ~ovr_clr) | (rise & pending_q & ~grant);
  end

  // Round-robin search: first pending channel at or after rr_ptr, wrapping.
  always_comb begin
    int sum;
    pick_found = 1'b0;
    pick_id    = '0;
    sum        = 0;
    for (int off = 0; off < N; off++) begin
      sum = int'(rr_ptr_q) + off;
      if (sum >= N) begin
        sum = sum - N;
      end
      if (!pick_found && pending_q[IDW'(sum)]) begin
        pick_found = 1'b1;
        pick_id    = IDW'(sum);
      end
    end
  end

  // FSM next-state: choose in IDLE, hold ev_id in OFFER until accepted.
  always_comb begin
    state_d    = state_q;
    ev_valid_d = ev_valid_q;
    ev_id_d    = ev_id_q;
    rr_ptr_d   = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d    = OFFER;
          ev_valid_d = 1'b1;
          ev_id_d    = pick_id;
        end
      end
      OFFER: begin
        if (ev_ready) begin
          state_d    = IDLE;
          ev_valid_d = 1'b0;
          if (ev_id_q == IDW'(N - 1)) begin
            rr_ptr_d = '0;
          end else begin
            rr_ptr_d = ev_id_q + 1'b1;
          end
        end
      end
      default: begin
        state_d    = IDLE;
        ev_valid_d = 1'b0;
      end
    endcase
  end

  // State register; reset drops any offered and pending events.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ev_valid_q <= 1'b0;
      ev_id_q    <= '0;
      rr_ptr_q   <= '0;
      lvl_q      <= '0;
      pending_q  <= '0;
      overrun_q  <= '0;
    end else begin
      state_q    <= state_d;
      ev_valid_q <= ev_valid_d;
      ev_id_q    <= ev_id_d;
      rr_ptr_q   <= rr_ptr_d;
      lvl_q      <= lvl_d;
      pending_q  <= pending_d;
      overrun_q  <= overrun_d;
    end
  end

  assign ev_valid = ev_valid_q;
  assign ev_id    = ev_id_q;
  assign pending  = pending_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Bench for edge_event_arbiter: directed scenarios followed by random traffic,
// checked against an event-level reference model and a queue of expected
// handshake ids.
module tb_edge_event_arbiter;

  localparam int N   = 4;
  localparam int IDW = $clog2(N);

  // ---------------- clock / reset ----------------
  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   level;
  logic           ev_valid;
  logic [IDW-1:0] ev_id;
  logic           ev_ready;
  logic [N-1:0]   pending;
  logic [N-1:0]   overrun;
  logic [N-1:0]   ovr_clr;

  always #5 clk = ~clk;

  edge_event_arbiter #(.N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .level    (level),
    .ev_valid (ev_valid),
    .ev_id    (ev_id),
    .ev_ready (ev_ready),
    .pending  (pending),
    .overrun  (overrun),
    .ovr_clr  (ovr_clr)
  );

  // ---------------- scoreboard state ----------------
  logic [IDW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int hs_pred = 0;
  int hs_seen = 0;

  // reference model: current (after last edge) and next (after coming edge)
  bit [N-1:0] m_lvl, m_pend, m_ovr;
  bit         m_valid;
  int         m_id, m_rr;
  bit [N-1:0] n_lvl, n_pend, n_ovr;
  bit         n_valid;
  int         n_id, n_rr;
  bit         model_ok = 1'b0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Event-level model of one clock edge with the given inputs.
  task automatic predict(input bit r, input bit [N-1:0] lv, input bit rdy, input bit [N-1:0] clr);
    bit hs;
    bit rs, g;
    if (r) begin
      n_lvl = '0; n_pend = '0; n_ovr = '0;
      n_valid = 1'b0; n_id = 0; n_rr = 0;
      return;
    end
    hs = m_valid && rdy;
    if (hs) begin
      exp_q.push_back(IDW'(m_id));
      hs_pred++;
    end
    for (int i = 0; i < N; i++) begin
      rs = lv[i] && !m_lvl[i];
      g  = hs && (m_id == i);
      n_ovr[i]  = (rs && m_pend[i] && !g) ? 1'b1 : (clr[i] ? 1'b0 : m_ovr[i]);
      n_pend[i] = rs ? 1'b1 : (g ? 1'b0 : m_pend[i]);
    end
    n_lvl = lv;
    n_valid = m_valid; n_id = m_id; n_rr = m_rr;
    if (m_valid) begin
      if (hs) begin
        n_rr    = (m_id + 1) % N;
        n_valid = 1'b0;
      end
    end else if (m_pend != '0) begin
      for (int k = 0; k < N; k++) begin
        if (m_pend[(m_rr + k) % N]) begin
          n_id    = (m_rr + k) % N;
          n_valid = 1'b1;
          break;
        end
      end
    end
  endtask

  // ---------------- driver ----------------
  task automatic drive(input bit r, input bit [N-1:0] lv, input bit rdy,
                       input bit [N-1:0] clr, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk);
      #2;
      m_lvl = n_lvl; m_pend = n_pend; m_ovr = n_ovr;
      m_valid = n_valid; m_id = n_id; m_rr = n_rr;
      model_ok = 1'b1;
      rst = r; level = lv; ev_ready = rdy; ovr_clr = clr;
      predict(r, lv, rdy, clr);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (model_ok) begin
        check("ev_valid", 32'(ev_valid), 32'(m_valid));
        check("pending", 32'(pending), 32'(m_pend));
        check("overrun", 32'(overrun), 32'(m_ovr));
        if (m_valid) check("ev_id_held", 32'(ev_id), 32'(m_id));
        if (ev_valid && ev_ready && !rst) begin
          hs_seen++;
          if (exp_q.size() == 0) begin
            check("unexpected_handshake", 32'(ev_id), 32'hFFFF);
          end else begin
            check("handshake_id", 32'(ev_id), 32'(exp_q.pop_front()));
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit [N-1:0] lv, clr;
    bit rdy, r;
    rst = 1'b1; level = '0; ev_ready = 1'b0; ovr_clr = '0;
    n_lvl = '0; n_pend = '0; n_ovr = '0; n_valid = 1'b0; n_id = 0; n_rr = 0;

    // T1 reset then single event on channel 0
    drive(1, 4'b0000, 0, 4'b0000, 2);
    drive(0, 4'b0000, 1, 4'b0000, 3);
    drive(0, 4'b0001, 1, 4'b0000, 5);
    // T2 all channels rise together, round-robin drain
    drive(0, 4'b0000, 1, 4'b0000, 2);
    drive(0, 4'b1111, 1, 4'b0000, 10);
    // T3 backpressure with a second channel rising
    drive(0, 4'b0000, 1, 4'b0000, 2);
    drive(0, 4'b0100, 0, 4'b0000, 2);
    drive(0, 4'b0110, 0, 4'b0000, 5);
    drive(0, 4'b0110, 1, 4'b0000, 6);
    // T4 overrun on channel 3, then clear
    drive(0, 4'b0000, 1, 4'b0000, 2);
    drive(0, 4'b1000, 0, 4'b0000, 1);
    drive(0, 4'b0000, 0, 4'b0000, 1);
    drive(0, 4'b1000, 0, 4'b0000, 2);
    drive(0, 4'b1000, 1, 4'b0000, 3);
    drive(0, 4'b1000, 1, 4'b1000, 1);
    drive(0, 4'b0000, 1, 4'b0000, 2);
    // T5 rise on channel 1 in its own handshake cycle
    drive(0, 4'b0010, 0, 4'b0000, 1);
    drive(0, 4'b0000, 0, 4'b0000, 2);
    drive(0, 4'b0010, 1, 4'b0000, 1);
    drive(0, 4'b0010, 1, 4'b0000, 6);
    // T6 reset while offering with ready high
    drive(0, 4'b0000, 0, 4'b0000, 1);
    drive(0, 4'b0101, 0, 4'b0000, 3);
    drive(1, 4'b0101, 1, 4'b0000, 1);
    drive(0, 4'b0101, 1, 4'b0000, 6);

    // random traffic
    lv = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) == 0) lv[i] = ~lv[i];
      end
      rdy = ($urandom_range(0, 2) != 0);
      clr = ($urandom_range(0, 7) == 0) ? N'($urandom_range(0, 15)) : '0;
      r   = ($urandom_range(0, 299) == 0);
      drive(r, lv, rdy, clr, 1);
    end

    // drain
    drive(0, lv, 1, 4'b0000, 12);
    @(negedge clk);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    check("handshake_count", 32'(hs_seen), 32'(hs_pred));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
